// File: rtl/serial_data_receiver.sv
// Serial frame receiver: start, DATA_WIDTH data bits (LSB first), parity and stop bit,
// sampled one bit per clock, with a one-cycle valid or error pulse per frame.
module serial_data_receiver #(
    parameter int DATA_WIDTH = 7,
    parameter bit ODD_PARITY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_data,
    output logic                  data_valid,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] out_data
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                state_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  parity_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  data_valid_reg;
    logic                  error_reg;
    logic                  parity_ok;

    // Data bits plus parity bit must have the configured ones-count parity.
    assign parity_ok = (((^shift_reg) ^ parity_reg) == ODD_PARITY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            parity_reg     <= 1'b0;
            out_data_reg   <= '0;
            data_valid_reg <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            error_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!in_data) begin
                        state_reg   <= DATA;
                        bit_cnt_reg <= '0;
                    end
                end
                DATA: begin
                    shift_reg[bit_cnt_reg] <= in_data;
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_reg   <= PARITY;
                        bit_cnt_reg <= '0;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                PARITY: begin
                    parity_reg <= in_data;
                    state_reg  <= STOP;
                end
                STOP: begin
                    if (in_data) begin
                        if (parity_ok) begin
                            out_data_reg   <= shift_reg;
                            data_valid_reg <= 1'b1;
                        end else begin
                            error_reg <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end else begin
                        // Broken stop bit: the line is low, so wait for it to
                        // return high before hunting for the next start bit.
                        error_reg <= 1'b1;
                        state_reg <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (in_data) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign data_valid = data_valid_reg;
    assign error      = error_reg;
    assign out_data   = out_data_reg;

endmodule

// File: tb/tb_serial_data_receiver.sv
// Self-checking bench for serial_data_receiver: directed frames plus random streams,
// compared cycle by cycle against a frame-level reference model.
module tb_serial_data_receiver;
    localparam int DW = 7;
    localparam bit ODD = 1'b1;

    logic          clk;
    logic          rst;
    logic          in_data;
    logic          data_valid;
    logic          error;
    logic [DW-1:0] out_data;

    int checks_cnt;
    int errors_cnt;

    logic          stream[$];
    logic          exp_dv[$];
    logic          exp_err[$];
    logic [DW-1:0] exp_pl[$];
    logic [DW-1:0] exp_out[$];
    logic [DW-1:0] model_out;

    serial_data_receiver #(
        .DATA_WIDTH(DW),
        .ODD_PARITY(ODD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .data_valid(data_valid),
        .error     (error),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic good_parity(input logic [DW-1:0] pl);
        return ODD ? ~(^pl) : (^pl);
    endfunction

    task automatic push_frame(input logic [DW-1:0] pl, input logic par, input logic stop);
        stream.push_back(1'b0);
        for (int b = 0; b < DW; b++) stream.push_back(pl[b]);
        stream.push_back(par);
        stream.push_back(stop);
    endtask

    task automatic push_bits(input logic v, input int n);
        for (int k = 0; k < n; k++) stream.push_back(v);
    endtask

    // Frame-level parse of the whole bit stream; entry k describes the outputs
    // just after the clock edge that sampled stream[k].
    task automatic build_expect();
        int i;
        int n;
        int s;
        logic [DW-1:0] pl;
        logic par;
        logic stop;
        logic ok;
        n = stream.size();
        exp_dv.delete();
        exp_err.delete();
        exp_pl.delete();
        exp_out.delete();
        for (int k = 0; k < n; k++) begin
            exp_dv.push_back(1'b0);
            exp_err.push_back(1'b0);
            exp_pl.push_back('0);
            exp_out.push_back('0);
        end
        i = 0;
        while (i < n) begin
            if (stream[i] == 1'b1) begin
                i++;
                continue;
            end
            if (i + DW + 2 >= n) break;
            for (int b = 0; b < DW; b++) pl[b] = stream[i + 1 + b];
            par  = stream[i + 1 + DW];
            stop = stream[i + 2 + DW];
            ok   = ((($countones(pl) + int'(par)) % 2) == int'(ODD));
            s    = i + DW + 2;
            if (stop && ok) begin
                exp_dv[s] = 1'b1;
                exp_pl[s] = pl;
            end else begin
                exp_err[s] = 1'b1;
            end
            i = s + 1;
            if (!stop) begin
                while (i < n && stream[i] == 1'b0) i++;
                i++;
            end
        end
        for (int k = 0; k < n; k++) begin
            if (exp_dv[k]) model_out = exp_pl[k];
            exp_out[k] = model_out;
        end
    endtask

    task automatic run_segment(input string name);
        build_expect();
        for (int k = 0; k < stream.size(); k++) begin
            @(negedge clk);
            in_data = stream[k];
            @(posedge clk);
            #1;
            check({name, ".data_valid"}, 32'(data_valid), 32'(exp_dv[k]));
            check({name, ".error"}, 32'(error), 32'(exp_err[k]));
            check({name, ".out_data"}, 32'(out_data), 32'(exp_out[k]));
            if (exp_dv[k])
                $display("%s: cycle %0d frame valid, out_data=0x%02h", name, k, exp_out[k]);
            if (exp_err[k])
                $display("%s: cycle %0d frame error, out_data=0x%02h", name, k, exp_out[k]);
        end
        stream.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        in_data = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_out = '0;
    endtask

    initial begin
        logic [DW-1:0] pl;
        int kind;
        checks_cnt = 0;
        errors_cnt = 0;
        rst = 1'b1;
        in_data = 1'b1;
        model_out = '0;
        #1;
        check("reset.data_valid", 32'(data_valid), 32'd0);
        check("reset.error", 32'(error), 32'd0);
        check("reset.out_data", 32'(out_data), 32'd0);
        apply_reset();

        // Idle line, then good / bad parity / framing error / back-to-back frames.
        push_bits(1'b1, 5);
        push_frame(7'h07, 1'b0, 1'b1);
        push_bits(1'b1, 2);
        push_frame(7'h0F, 1'b0, 1'b1);
        push_bits(1'b1, 2);
        push_frame(7'h1F, 1'b0, 1'b0);
        push_bits(1'b0, 3);
        push_bits(1'b1, 2);
        push_frame(7'h41, 1'b1, 1'b1);
        push_frame(7'h03, 1'b1, 1'b1);
        push_bits(1'b1, 2);
        run_segment("directed");

        // Abort mid-frame: good frame first so the clear of out_data is visible.
        push_frame(7'h2A, good_parity(7'h2A), 1'b1);
        push_bits(1'b1, 1);
        stream.push_back(1'b0);
        push_bits(1'b1, 3);
        run_segment("pre_abort");
        @(negedge clk);
        in_data = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("abort.out_data", 32'(out_data), 32'd0);
        check("abort.data_valid", 32'(data_valid), 32'd0);
        check("abort.error", 32'(error), 32'd0);
        @(negedge clk);
        in_data = 1'b1;
        rst = 1'b0;
        model_out = '0;
        push_bits(1'b1, 12);
        push_frame(7'h55, 1'b1, 1'b1);
        push_bits(1'b1, 2);
        run_segment("post_abort");

        // Random mix of frames, line noise and framing errors.
        for (int seg = 0; seg < 4; seg++) begin
            apply_reset();
            for (int f = 0; f < 25; f++) begin
                push_bits(1'b1, $urandom_range(0, 2));
                pl = DW'($urandom);
                kind = $urandom_range(0, 9);
                if (kind <= 5) begin
                    push_frame(pl, good_parity(pl), 1'b1);
                end else if (kind <= 7) begin
                    push_frame(pl, ~good_parity(pl), 1'b1);
                end else if (kind == 8) begin
                    push_frame(pl, 1'($urandom), 1'b0);
                    push_bits(1'b0, $urandom_range(0, 3));
                    push_bits(1'b1, 1);
                end else begin
                    for (int k = 0; k < 4; k++) stream.push_back(1'($urandom));
                    push_bits(1'b1, DW + 3);
                end
            end
            push_bits(1'b1, DW + 3);
            run_segment("random");
        end

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
